event_scheduler: RTL and testbench
==================================

// Module: event_scheduler
// PURPOSE
//  Time-step scheduler for the emulated link; sits between the event requesters (TX, channel filter, RX, CDR) and the datapath.
//  - Each requester posts a relative delay to its next event.
//  - The block picks the earliest pending event and advances emulated time to it.
//  - It flags which requesters fire at that time, giving filter blocks their time_next and time_eq_in.
//  - Run/step control lets the host pause, run or single-step emulated time.
// PARAMETERS
//  N_REQ       4           number of requesters
//  TIME_WIDTH  TIME_WIDTH  absolute emulated time width (time_package), unsigned
//  DT_WIDTH    DT_WIDTH    relative delay width (time_package), unsigned, same LSB as time
//  CNT_WIDTH   32          width of the step counter
// PORTS
//  clk_sys     in   1                 system clock
//  rst         in   1                 synchronous reset, active-high
//  run_en      in   1                 1 = advance continuously
//  step_req    in   1                 1-cycle pulse: single advance while run_en=0
//  req_valid   in   N_REQ             requester i has a pending event
//  dt_req      in   N_REQ*DT_WIDTH    delay of requester i from current time_next; slice i = [i*DT_WIDTH +: DT_WIDTH]
//  time_next   out  TIME_WIDTH        absolute time of the event flagged on time_eq
//  time_eq     out  N_REQ             1-cycle pulse per requester firing at time_next
//  step_count  out  CNT_WIDTH         number of advances since reset; wraps
//  stalled     out  1                 running, but no requester valid
//  err_dt_zero out  1                 sticky: a winning dt_req was 0
//  time_wrap   out  1                 sticky: time_next wrapped past 2^TIME_WIDTH
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; all outputs 0. Reset wins over every other input in any state.
//  FSM states: IDLE, SETTLE, ADVANCE, STALL.
//   - IDLE:
//     - run_en=1 or step_req=1 -> SETTLE.
//     - step_req is latched as step_pend; step_pend clears on the next ADVANCE.
//   - SETTLE: one cycle so requesters can update dt_req after a time_eq pulse.
//     - Then -> ADVANCE if any req_valid, else -> STALL.
//   - ADVANCE: single cycle.
//     - dt_min = min of dt_req[i] over valid i. Ties: all tied requesters fire together.
//     - If dt_min==0: use 1 LSB and set err_dt_zero.
//     - Registered on exit: time_next <= time_next + dt_min (modulo 2^TIME_WIDTH); set time_wrap on carry-out.
//     - Registered on exit: time_eq <= mask of valid i with dt_req[i]==dt_min (raw, pre-clamp).
//     - Registered on exit: step_count++.
//     - Next state: SETTLE if run_en=1, else IDLE.
//   - STALL:
//     - stalled=1 (Moore output).
//     - Any req_valid -> ADVANCE.
//     - run_en=0 with no step_pend -> IDLE.
//  time_eq:
//   - High exactly the cycle after ADVANCE, coincident with the new time_next; 0 in every other cycle.
//   - time_next is stable from that cycle until the next ADVANCE exit.
//  Latency:
//   - run_en rising to first time_eq: 3 cycles (IDLE -> SETTLE -> ADVANCE -> pulse).
//   - Steady state: one advance per 2 cycles.
//  Run/step interaction:
//   - step_req while run_en=1 is ignored.
//   - run_en falling mid-SETTLE completes that advance, then goes to IDLE.
//   - req_valid dropping during SETTLE of a step: step_pend stays set; state goes to STALL until a requester appears.
//  Arithmetic:
//   - All unsigned.
//   - dt_min is zero-extended to TIME_WIDTH before the add.
//   - No saturation on time or step_count.
// STRUCTURE
//  time_package: TIME_WIDTH, DT_WIDTH, TIME_FORMAT, DT_FORMAT (existing); add SCHED_N_REQ and a sched_state_t enum.
//  Sub-module min_tree:
//   - Combinational, parameterised N and W.
//   - Inputs: valid and values. Outputs: min value and any_valid.
//   - Log2 depth; invalid leaves treat their value as all-ones.
//  Tie mask is formed in event_scheduler by comparing each valid dt_req with the min_tree output.
// TESTING
//  1. Reset with run_en=1, dt_req={5,3,7,3}, all valid.
//     -> First time_eq=4'b1010 with time_next=3, on cycle 3 after rst drop.
//  2. Hold all dt_req constant at 4, run 10 advances.
//     -> time_next = 4,8,...,40; time_eq pulses every 2nd cycle; step_count=10.
//  3. run_en=0, three step_req pulses 10 cycles apart, dt=2.
//     -> Exactly 3 time_eq pulses; time_next=6; state IDLE between pulses.
//  4. run_en=1, req_valid=0 for 20 cycles, then req_valid[2]=1 with dt=9.
//     -> stalled=1 throughout the gap; then time_eq=4'b0100 with time_next += 9; stalled=0.
//  5. Start at time_next=2^TIME_WIDTH-2, dt=5.
//     -> time_next=3, time_wrap=1. A winning dt=0 -> time advances by 1, err_dt_zero=1.
//  6. Assert rst during ADVANCE.
//     -> Next cycle: time_eq=0, time_next=0, step_count=0, flags 0, state IDLE.

Source files
------------

// File: rtl/time_package.sv
// Shared time-base definitions for the emulated link.
// Contents:
//   TIME_WIDTH / DT_WIDTH  widths of absolute time and relative delay (same LSB)
//   TIME_FORMAT/DT_FORMAT  fractional bits carried in the time / delay LSB
//   SCHED_N_REQ            number of requesters served by event_scheduler
//   sched_state_t          event_scheduler FSM state encoding
package time_package;

  localparam int TIME_WIDTH  = 16;
  localparam int DT_WIDTH    = 8;
  localparam int TIME_FORMAT = 0;
  localparam int DT_FORMAT   = 0;

  localparam int SCHED_N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_STALL   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/min_tree.sv
// Combinational minimum over N W-bit values with per-leaf valid.
// Ports:
//   valid_i      leaf i participates when set
//   value_i      leaf values, slice i = [i*W +: W]
//   min_o        smallest valid value (all-ones when nothing is valid)
//   any_valid_o  at least one leaf is valid
// Leaves are padded to a power of two; invalid and padding leaves read as
// all-ones so they never win against a real value.
module min_tree #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]   valid_i,
  input  logic [N*W-1:0] value_i,
  output logic [W-1:0]   min_o,
  output logic           any_valid_o
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
  localparam int LEAVES = 1 << LEVELS;

  genvar gl, gi;

  // Level 0 holds the leaves; level gl holds LEAVES>>gl pairwise minima.
  for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
    localparam int NODES = LEAVES >> gl;
    logic [W-1:0] node [NODES];

    if (gl == 0) begin : g_leaf
      for (gi = 0; gi < LEAVES; gi++) begin : g_in
        if (gi < N) begin : g_real
          assign node[gi] = valid_i[gi] ? value_i[gi*W +: W] : {W{1'b1}};
        end else begin : g_pad
          assign node[gi] = {W{1'b1}};
        end
      end
    end else begin : g_node
      for (gi = 0; gi < NODES; gi++) begin : g_pair
        assign node[gi] = (g_lvl[gl-1].node[2*gi] <= g_lvl[gl-1].node[2*gi+1])
                          ? g_lvl[gl-1].node[2*gi] : g_lvl[gl-1].node[2*gi+1];
      end
    end
  end

  assign min_o       = g_lvl[LEVELS].node[0];
  assign any_valid_o = |valid_i;

endmodule

// File: rtl/event_scheduler.sv
// Time-step scheduler: picks the earliest pending requester event, advances
// emulated time to it and pulses time_eq for every requester firing there.
// Ports:
//   clk_sys, rst   clock and synchronous active-high reset
//   run_en         advance continuously while set
//   step_req       one-cycle pulse requesting a single advance while paused
//   req_valid      requester i has a pending event
//   dt_req         delay of requester i from time_next, slice [i*DT_WIDTH +: DT_WIDTH]
//   time_next      absolute time of the event flagged on time_eq
//   time_eq        one-cycle firing mask, coincident with the new time_next
//   step_count     advances since reset (wraps)
//   stalled        running but no requester valid
//   err_dt_zero    sticky: a winning delay was 0 (time advanced by 1 instead)
//   time_wrap      sticky: time_next wrapped
module event_scheduler #(
  parameter int N_REQ      = time_package::SCHED_N_REQ,
  parameter int TIME_WIDTH = time_package::TIME_WIDTH,
  parameter int DT_WIDTH   = time_package::DT_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic                      run_en,
  input  logic                      step_req,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  output logic [TIME_WIDTH-1:0]     time_next,
  output logic [N_REQ-1:0]          time_eq,
  output logic [CNT_WIDTH-1:0]      step_count,
  output logic                      stalled,
  output logic                      err_dt_zero,
  output logic                      time_wrap
);

  import time_package::*;

  sched_state_t          state_q, state_d;
  logic                  step_pend_q, step_pend_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic [N_REQ-1:0]      eq_q, eq_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  wrap_q, wrap_d;

  logic [DT_WIDTH-1:0]   dt_min;
  logic                  any_valid;
  logic [N_REQ-1:0]      tie_mask;
  logic [DT_WIDTH-1:0]   dt_step;
  logic [TIME_WIDTH:0]   time_sum;

  min_tree #(
    .N (N_REQ),
    .W (DT_WIDTH)
  ) u_min_tree (
    .valid_i     (req_valid),
    .value_i     (dt_req),
    .min_o       (dt_min),
    .any_valid_o (any_valid)
  );

  // Every valid requester whose delay equals the minimum fires together.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_tie
    assign tie_mask[gi] = req_valid[gi] && (dt_req[gi*DT_WIDTH +: DT_WIDTH] == dt_min);
  end

  // A zero delay would stall time forever; step one LSB instead.
  assign dt_step  = (dt_min == '0) ? DT_WIDTH'(1) : dt_min;
  assign time_sum = {1'b0, time_q} + (TIME_WIDTH + 1)'(dt_step);

  // State register
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_pend_q <= 1'b0;
      time_q      <= '0;
      eq_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      time_q      <= time_d;
      eq_q        <= eq_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (run_en || step_req) state_d = ST_SETTLE;
      ST_SETTLE:  state_d = any_valid ? ST_ADVANCE : ST_STALL;
      ST_ADVANCE: state_d = run_en ? ST_SETTLE : ST_IDLE;
      ST_STALL: begin
        if (any_valid)                      state_d = ST_ADVANCE;
        else if (!run_en && !step_pend_q)   state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    stalled     = (state_q == ST_STALL);
    step_pend_d = step_pend_q;
    time_d      = time_q;
    eq_d        = '0;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wrap_d      = wrap_q;

    // A step only counts while paused; during run it is ignored.
    if (state_q == ST_IDLE && step_req && !run_en) step_pend_d = 1'b1;

    if (state_q == ST_ADVANCE) begin
      step_pend_d = 1'b0;
      // Requesters may withdraw in the ADVANCE cycle itself; with nobody
      // left there is no event to move time to, so nothing is committed.
      if (any_valid) begin
        time_d = time_sum[TIME_WIDTH-1:0];
        eq_d   = tie_mask;
        cnt_d  = cnt_q + CNT_WIDTH'(1);
        if (dt_min == '0)         err_d  = 1'b1;
        if (time_sum[TIME_WIDTH]) wrap_d = 1'b1;
      end
    end
  end

  assign time_next   = time_q;
  assign time_eq     = eq_q;
  assign step_count  = cnt_q;
  assign err_dt_zero = err_q;
  assign time_wrap   = wrap_q;

endmodule

// File: tb/tb_event_scheduler.sv
module tb_event_scheduler;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int DW = 8;
  localparam int CW = 32;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          run_en = 1'b0;
  logic          step_req = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] dt_req = '0;
  logic [TW-1:0] time_next;
  logic [N-1:0]  time_eq;
  logic [CW-1:0] step_count;
  logic          stalled, err_dt_zero, time_wrap;

  always #5 clk_sys = ~clk_sys;

  event_scheduler #(
    .N_REQ      (N),
    .TIME_WIDTH (TW),
    .DT_WIDTH   (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .run_en      (run_en),
    .step_req    (step_req),
    .req_valid   (req_valid),
    .dt_req      (dt_req),
    .time_next   (time_next),
    .time_eq     (time_eq),
    .step_count  (step_count),
    .stalled     (stalled),
    .err_dt_zero (err_dt_zero),
    .time_wrap   (time_wrap)
  );

  int total = 0;
  int bad = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // dt listed in requester order 0..3
  task automatic set_dt(input int d0, input int d1, input int d2, input int d3);
    dt_req = {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endtask

  task automatic wait_pulse(input string name);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (time_eq != '0) return;
    end
    total++;
    bad++;
    $display("FAIL %s: got=no time_eq pulse expected=pulse within 8 cycles", name);
  endtask

  // Reference model: on every firing, the new time is old time plus the
  // smallest valid delay (0 counts as 1), the mask is everyone at that
  // minimum, and counters/flags follow. Inputs are sampled at the edge the
  // DUT used, outputs checked at the following falling edge.
  logic [TW-1:0] m_time;
  logic [CW-1:0] m_cnt;
  logic          m_err, m_wrap;

  initial begin
    logic            s_rst;
    logic [N-1:0]    s_valid;
    logic [N*DW-1:0] s_dt;
    logic [N-1:0]    mask;
    int              mn, d, sum;
    m_time = '0; m_cnt = '0; m_err = 1'b0; m_wrap = 1'b0;
    forever begin
      @(posedge clk_sys);
      s_rst = rst; s_valid = req_valid; s_dt = dt_req;
      @(negedge clk_sys);
      if (s_rst) begin
        m_time = '0; m_cnt = '0; m_err = 1'b0; m_wrap = 1'b0;
        check("rst_eq", time_eq, 0);
        check("rst_stalled", stalled, 0);
      end else if (time_eq != '0) begin
        mn = 1 << DW;
        for (int i = 0; i < N; i++) begin
          d = int'(s_dt[i*DW +: DW]);
          if (s_valid[i] && d < mn) mn = d;
        end
        for (int i = 0; i < N; i++)
          mask[i] = s_valid[i] && (int'(s_dt[i*DW +: DW]) == mn);
        sum = int'(m_time) + ((mn == 0) ? 1 : mn);
        if (sum >= (1 << TW)) m_wrap = 1'b1;
        if (mn == 0) m_err = 1'b1;
        m_time = TW'(sum % (1 << TW));
        m_cnt  = m_cnt + 1;
        pulse_cnt++;
        check("model_mask", time_eq, mask);
      end
      check("model_time", time_next, m_time);
      check("model_count", step_count, m_cnt);
      check("model_err", err_dt_zero, m_err);
      check("model_wrap", time_wrap, m_wrap);
    end
  end

  initial begin
    int t, p0, d;

    // 1: reset with run_en high, dt = {5,3,7,3}
    rst = 1'b1; run_en = 1'b1; req_valid = 4'hF; set_dt(5, 3, 7, 3);
    repeat (3) tick();
    check("reset_time", time_next, 0);
    check("reset_count", step_count, 0);
    check("reset_eq", time_eq, 0);
    check("reset_flags", {stalled, err_dt_zero, time_wrap}, 0);
    rst = 1'b0;
    tick(); check("t1_cyc1_eq", time_eq, 0);
    tick(); check("t1_cyc2_eq", time_eq, 0);
    tick(); check("t1_cyc3_eq", time_eq, 4'b1010);
    check("t1_time", time_next, 3);
    check("t1_count", step_count, 1);

    // 2: constant dt=4, exactly 10 advances
    rst = 1'b1; set_dt(4, 4, 4, 4); tick(); rst = 1'b0;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick(); check("t2_gap_eq", time_eq, 0);
      if (k == 10) run_en = 1'b0;
      tick();
      check("t2_eq", time_eq, 4'hF);
      check("t2_time", time_next, 4 * k);
    end
    repeat (4) tick();
    check("t2_count", step_count, 10);
    check("t2_hold_time", time_next, 40);
    check("t2_hold_eq", time_eq, 0);

    // 3: three single steps, dt=2
    rst = 1'b1; tick(); rst = 1'b0; set_dt(2, 2, 2, 2);
    p0 = pulse_cnt;
    for (int k = 1; k <= 3; k++) begin
      step_req = 1'b1; tick(); step_req = 1'b0;
      tick(); check("t3_pre_eq", time_eq, 0);
      tick(); check("t3_eq", time_eq, 4'hF);
      check("t3_time", time_next, 2 * k);
      repeat (7) begin
        tick();
        check("t3_idle_eq", time_eq, 0);
        check("t3_idle_stalled", stalled, 0);
      end
    end
    check("t3_pulses", pulse_cnt - p0, 3);
    check("t3_time_final", time_next, 6);

    // 4: run with no requesters, then requester 2 at dt=9
    run_en = 1'b1; req_valid = 4'b0000;
    tick(); tick();
    check("t4_stall_entry", stalled, 1);
    repeat (20) begin
      tick();
      check("t4_stalled", stalled, 1);
      check("t4_stall_eq", time_eq, 0);
    end
    req_valid = 4'b0100; set_dt(0, 0, 9, 0);
    tick(); check("t4_unstall", stalled, 0);
    tick();
    check("t4_eq", time_eq, 4'b0100);
    check("t4_time", time_next, 15);
    check("t4_stalled_after", stalled, 0);
    check("t4_no_err", err_dt_zero, 0);

    // 5: drive time to 2^TW-2, then wrap with dt=5, then a zero delay
    rst = 1'b1; req_valid = 4'b0001; set_dt(255, 0, 0, 0); tick();
    rst = 1'b0; tick();
    t = 0;
    while (t != (1 << TW) - 2) begin
      d = ((1 << TW) - 2 - t > 255) ? 255 : (1 << TW) - 2 - t;
      set_dt(d, 0, 0, 0);
      wait_pulse("t5_ramp_pulse");
      t = t + d;
    end
    check("t5_pre_time", time_next, (1 << TW) - 2);
    check("t5_pre_wrap", time_wrap, 0);
    set_dt(5, 0, 0, 0); wait_pulse("t5_wrap_pulse");
    check("t5_wrap_time", time_next, 3);
    check("t5_wrap_flag", time_wrap, 1);
    check("t5_wrap_err", err_dt_zero, 0);
    set_dt(0, 0, 0, 0); wait_pulse("t5_zero_pulse");
    check("t5_zero_time", time_next, 4);
    check("t5_zero_err", err_dt_zero, 1);
    check("t5_zero_eq", time_eq, 4'b0001);

    // 6: reset asserted while in ADVANCE
    tick();
    rst = 1'b1; tick();
    check("t6_eq", time_eq, 0);
    check("t6_time", time_next, 0);
    check("t6_count", step_count, 0);
    check("t6_flags", {stalled, err_dt_zero, time_wrap}, 0);
    rst = 1'b0; run_en = 1'b0;
    repeat (3) tick();
    check("t6_idle_eq", time_eq, 0);
    check("t6_idle_time", time_next, 0);
    check("t6_idle_count", step_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
